// File: rtl/rect_scan_ctrl.sv
// rect_scan_ctrl: per-pixel rectangle scan sequencer; the last covering rectangle's colour wins.
module rect_scan_ctrl #(
  parameter int COORD_WIDTH = 16,
  parameter int COLOR_WIDTH = 16,
  parameter int RECT_COUNT  = 64,
  parameter int ADDR_WIDTH  = $clog2(RECT_COUNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          px_valid_i,
  output logic                          px_ready_o,
  input  logic signed [COORD_WIDTH-1:0] px_x_i,
  input  logic signed [COORD_WIDTH-1:0] px_y_i,
  input  logic        [COLOR_WIDTH-1:0] bg_color_i,
  input  logic        [ADDR_WIDTH:0]    num_rects_i,
  output logic                          rect_rd_en_o,
  output logic        [ADDR_WIDTH-1:0]  rect_addr_o,
  input  logic signed [COORD_WIDTH-1:0] rect_left_i,
  input  logic signed [COORD_WIDTH-1:0] rect_top_i,
  input  logic signed [COORD_WIDTH-1:0] rect_right_i,
  input  logic signed [COORD_WIDTH-1:0] rect_bottom_i,
  input  logic        [COLOR_WIDTH-1:0] rect_color_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic        [COLOR_WIDTH-1:0] out_color_o,
  output logic                          out_hit_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [ADDR_WIDTH:0] MAX_N = (ADDR_WIDTH+1)'(RECT_COUNT);
  logic [1:0] state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH:0] n_q, n_d, n_in;
  logic signed [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [COLOR_WIDTH-1:0] color_q, color_d;
  logic hit_q, hit_d, rdy_q, dv_q;
  logic acc, last, hit_now;
  assign acc  = px_valid_i && rdy_q;
  assign n_in = num_rects_i > MAX_N ? MAX_N : num_rects_i;
  assign last = {1'b0, cnt_q} == n_q - 1'b1;
  // dv_q marks read data returning one cycle after its strobe
  assign hit_now = dv_q && rect_left_i <= x_q && x_q < rect_right_i
                        && rect_top_i <= y_q && y_q < rect_bottom_i;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = hit_now ? rect_color_i : color_q;
    hit_d   = hit_q | hit_now;
    case (state_q)
      IDLE: if (acc) begin
        x_d     = px_x_i;
        y_d     = px_y_i;
        n_d     = n_in;
        cnt_d   = '0;
        color_d = bg_color_i;
        hit_d   = 1'b0;
        state_d = n_in == '0 ? DONE : SCAN;
      end
      SCAN: begin
        cnt_d   = last ? cnt_q : cnt_q + 1'b1;
        state_d = last ? DRAIN : SCAN;
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      hit_q   <= 1'b0;
      rdy_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      hit_q   <= hit_d;
      rdy_q   <= state_d == IDLE;
      dv_q    <= state_q == SCAN;
    end
  end
  assign px_ready_o   = rdy_q;
  assign rect_rd_en_o = state_q == SCAN;
  assign rect_addr_o  = cnt_q;
  assign out_valid_o  = state_q == DONE;
  assign out_color_o  = color_q;
  assign out_hit_o    = hit_q;
endmodule

// File: tb/tb_rect_scan_ctrl.sv
// tb_rect_scan_ctrl: vector table, hand sequences and random pixels against a painter's-order model.
module tb_rect_scan_ctrl;
  localparam int RC = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic px_valid = 1'b0, px_ready;
  logic signed [15:0] px_x = '0, px_y = '0;
  logic [15:0] bg_color = '0;
  logic [6:0] num_rects = '0;
  logic rect_rd_en;
  logic [5:0] rect_addr;
  logic signed [15:0] rl = '0, rt = '0, rr = '0, rb = '0;
  logic [15:0] rc = '0;
  logic out_valid, out_ready = 1'b1, out_hit;
  logic [15:0] out_color;
  int total = 0, bad = 0;
  int ml[RC], mt[RC], mr[RC], mb[RC];
  logic [15:0] mc[RC];
  int addrs[$];

  typedef struct {int x; int y; int bg; int num; int ec; int eh;} vec_t;
  vec_t tv[11];

  always #5 clk = ~clk;

  rect_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .px_valid_i(px_valid), .px_ready_o(px_ready),
    .px_x_i(px_x), .px_y_i(px_y), .bg_color_i(bg_color), .num_rects_i(num_rects),
    .rect_rd_en_o(rect_rd_en), .rect_addr_o(rect_addr),
    .rect_left_i(rl), .rect_top_i(rt), .rect_right_i(rr), .rect_bottom_i(rb),
    .rect_color_i(rc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_color_o(out_color), .out_hit_o(out_hit)
  );

  always @(posedge clk) if (rect_rd_en) begin
    rl <= 16'(ml[rect_addr]);
    rt <= 16'(mt[rect_addr]);
    rr <= 16'(mr[rect_addr]);
    rb <= 16'(mb[rect_addr]);
    rc <= mc[rect_addr];
  end

  always @(negedge clk) if (rect_rd_en) addrs.push_back(int'(rect_addr));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic set_rect(input int i, input int l, input int t, input int r, input int b, input int c);
    ml[i] = l; mt[i] = t; mr[i] = r; mb[i] = b; mc[i] = 16'(c);
  endtask

  // Painter's order: scan every active entry, the last one covering the pixel wins.
  task automatic model(input int x, input int y, input int num, input int bg, output int ec, output int eh);
    int n;
    n = num > RC ? RC : num;
    ec = bg; eh = 0;
    for (int i = 0; i < n; i++)
      if (ml[i] <= x && x < mr[i] && mt[i] <= y && y < mb[i]) begin
        ec = int'(mc[i]); eh = 1;
      end
  endtask

  task automatic start(input int x, input int y, input int bg, input int num);
    int w;
    w = 0;
    while (!px_ready && w < 200) begin @(negedge clk); w++; end
    chk("px_ready_wait", int'(px_ready), 1);
    px_x = 16'(x); px_y = 16'(y); bg_color = 16'(bg); num_rects = 7'(num);
    px_valid = 1'b1;
    addrs.delete();
    @(posedge clk);
    @(negedge clk);
    px_valid = 1'b0;
  endtask

  task automatic run(input int x, input int y, input int bg, input int num, input int ec, input int eh, input string nm);
    int lat, n, ok;
    n = num > RC ? RC : num;
    start(x, y, bg, num);
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    chk({nm, "_latency"}, lat + 1, n == 0 ? 1 : n + 2);
    chk({nm, "_color"}, int'(out_color), ec);
    chk({nm, "_hit"}, int'(out_hit), eh);
    ok = addrs.size() == n;
    foreach (addrs[i]) if (addrs[i] != i) ok = 0;
    chk({nm, "_addr_seq"}, ok, 1);
    @(negedge clk);
    chk({nm, "_valid_drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int ec, eh, n, x, y, seen;
    string nm;
    for (int i = 0; i < RC; i++) set_rect(i, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("rst_px_ready", int'(px_ready), 0);
    chk("rst_rd_en", int'(rect_rd_en), 0);
    chk("rst_addr", int'(rect_addr), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_color", int'(out_color), 0);
    chk("rst_out_hit", int'(out_hit), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_px_ready", int'(px_ready), 1);

    run(3, 3, 'h1234, 0, 'h1234, 0, "n0");

    set_rect(0, 0, 0, 10, 10, 'hAAAA);
    set_rect(1, 5, 5, 15, 15, 'hBBBB);
    tv[0]  = '{7, 7, 'h0F0F, 2, 'hBBBB, 1};
    tv[1]  = '{2, 2, 'h0F0F, 2, 'hAAAA, 1};
    tv[2]  = '{20, 20, 'h0F0F, 2, 'h0F0F, 0};
    tv[3]  = '{5, 5, 'h0F0F, 2, 'hBBBB, 1};
    tv[4]  = '{4, 4, 'h0F0F, 2, 'hAAAA, 1};
    tv[5]  = '{12, 12, 'h0F0F, 2, 'hBBBB, 1};
    tv[6]  = '{0, 0, 'h1111, 1, 'hAAAA, 1};
    tv[7]  = '{10, 5, 'h1111, 1, 'h1111, 0};
    tv[8]  = '{5, 10, 'h1111, 1, 'h1111, 0};
    tv[9]  = '{9, 9, 'h1111, 1, 'hAAAA, 1};
    tv[10] = '{12, 12, 'h2222, 1, 'h2222, 0};
    foreach (tv[i]) begin
      $sformat(nm, "vec%0d", i);
      run(tv[i].x, tv[i].y, tv[i].bg, tv[i].num, tv[i].ec, tv[i].eh, nm);
    end

    set_rect(0, -5, -5, 5, 5, 'hCCCC);
    run(-1, -1, 'h0101, 1, 'hCCCC, 1, "signed_hit");
    run(-6, 0, 'h0101, 1, 'h0101, 0, "signed_miss");

    for (int i = 0; i < RC; i++) set_rect(i, -30, -30, -20, -20, i);
    set_rect(RC - 1, 0, 0, 5, 5, 'h5A5A);
    run(3, 3, 'h0707, RC + 1, 'h5A5A, 1, "full_clamp");

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < RC; i++)
        set_rect(i, int'($urandom_range(0, 40)) - 20, int'($urandom_range(0, 40)) - 20, 0, 0, int'($urandom_range(0, 'hFFFF)));
      for (int i = 0; i < RC; i++) begin
        mr[i] = ml[i] + int'($urandom_range(0, 18)) - 3;
        mb[i] = mt[i] + int'($urandom_range(0, 18)) - 3;
      end
      n = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 4)) : int'($urandom_range(0, RC + 2));
      x = int'($urandom_range(0, 50)) - 25;
      y = int'($urandom_range(0, 50)) - 25;
      model(x, y, n, 'h3C3C, ec, eh);
      $sformat(nm, "rand%0d", k);
      run(x, y, 'h3C3C, n, ec, eh, nm);
    end

    set_rect(0, 0, 0, 10, 10, 'hAAAA);
    set_rect(1, 5, 5, 15, 15, 'hBBBB);
    out_ready = 1'b0;
    start(7, 7, 'h0F0F, 2);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_color", int'(out_color), 'hBBBB);
      chk("bp_hit", int'(out_hit), 1);
      chk("bp_px_ready", int'(px_ready), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_px_ready", int'(px_ready), 1);

    for (int i = 0; i < RC; i++) set_rect(i, 0, 0, 10, 10, 'h4444);
    start(3, 3, 'h0F0F, RC);
    repeat (5) @(negedge clk);
    chk("mid_scan_rd_en", int'(rect_rd_en), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_px_ready", int'(px_ready), 0);
    chk("abort_rd_en", int'(rect_rd_en), 0);
    chk("abort_addr", int'(rect_addr), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_color", int'(out_color), 0);
    chk("abort_out_hit", int'(out_hit), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (80) begin @(negedge clk); if (out_valid || rect_rd_en) seen = 1; end
    chk("abort_no_result", seen, 0);
    chk("abort_px_ready_after", int'(px_ready), 1);
    run(7, 7, 'h0F0F, 1, 'h4444, 1, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
